// File: rtl/mix_imix_pkg.sv
// Shared types and GF(2^8) helpers for the MixColumns/InvMixColumns scheduler.
// The gmul helpers use the AES reduction polynomial 0x11B.
package mix_imix_pkg;

  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  typedef logic [7:0]                  byte_t;
  typedef logic [COL_W-1:0]            col_t;
  typedef logic [NUM_COLS*COL_W-1:0]   state_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } fsm_state_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul02(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t gmul03(input byte_t b);
    return xtime(b) ^ b;
  endfunction

  function automatic byte_t gmul09(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t gmul0b(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t gmul0d(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t gmul0e(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_imix_column.sv
// Combinational single-column MixColumns (inv=0) or InvMixColumns (inv=1).
// Byte 0 of the column is the most significant byte.
module mix_imix_column
  import mix_imix_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             inv,
  output logic [COL_W-1:0] col_out
);

  byte_t a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  always_comb begin
    if (inv) begin
      col_out = {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
                 gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
                 gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
                 gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
    end else begin
      col_out = {gmul02(a0) ^ gmul03(a1) ^ a2         ^ a3,
                 a0         ^ gmul02(a1) ^ gmul03(a2) ^ a3,
                 a0         ^ a1         ^ gmul02(a2) ^ gmul03(a3),
                 gmul03(a0) ^ a1         ^ a2         ^ gmul02(a3)};
    end
  end

endmodule

// File: rtl/mix_imix_col_scheduler.sv
// Round-robin arbiter sharing one mix/imix column unit between two requesters.
// The accepted state is transformed in place in out_state, one column per cycle.
module mix_imix_col_scheduler
  import mix_imix_pkg::*;
#(
  parameter int   CNT_W   = 16,
  parameter logic RR_INIT = 1'b0
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [127:0]     req0_state,
  input  logic [127:0]     req1_state,
  input  logic [1:0]       req_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             out_id,
  output logic             out_inv,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fsm_state_e state, next_state;
  logic [1:0] col_cnt;
  logic       last_grant;
  logic       winner;
  logic       accept;
  col_t       col_in, col_out;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  assign accept = (state == ST_IDLE) && (|req_valid);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (|req_valid)           next_state = ST_COMPUTE;
      ST_COMPUTE: if (col_cnt == LAST_COL)  next_state = ST_DONE;
      ST_DONE:    if (out_ready)            next_state = ST_IDLE;
      default:                              next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = (|req_valid) ? (winner ? 2'b10 : 2'b01) : 2'b00;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (col_cnt)
      2'd0:    col_in = out_state[127:96];
      2'd1:    col_in = out_state[95:64];
      2'd2:    col_in = out_state[63:32];
      default: col_in = out_state[31:0];
    endcase
  end

  mix_imix_column u_column (
    .col_in  (col_in),
    .inv     (out_inv),
    .col_out (col_out)
  );

  // Result register doubles as the working copy; inv and id are frozen at accept.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      col_cnt    <= 2'd0;
      out_state  <= '0;
      out_id     <= 1'b0;
      out_inv    <= 1'b0;
      last_grant <= ~RR_INIT;
      done_cnt0  <= '0;
      done_cnt1  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            out_state  <= winner ? req1_state : req0_state;
            out_inv    <= req_inv[winner];
            out_id     <= winner;
            last_grant <= winner;
            col_cnt    <= 2'd0;
          end
        end
        ST_COMPUTE: begin
          case (col_cnt)
            2'd0:    out_state[127:96] <= col_out;
            2'd1:    out_state[95:64]  <= col_out;
            2'd2:    out_state[63:32]  <= col_out;
            default: out_state[31:0]   <= col_out;
          endcase
          col_cnt <= col_cnt + 2'd1;
        end
        ST_DONE: begin
          if (out_ready) begin
            if (out_id) done_cnt1 <= done_cnt1 + CNT_ONE;
            else        done_cnt0 <= done_cnt0 + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_imix_col_scheduler.sv
// Self-checking bench for mix_imix_col_scheduler: directed AES vectors plus
// randomized traffic checked against a matrix-level GF(2^8) reference model.
module tb_mix_imix_col_scheduler;

  localparam int   CNT_W   = 16;
  localparam logic RR_INIT = 1'b0;

  typedef logic [127:0] blk_t;

  logic             ACLK = 1'b0;
  logic             ARESET = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  blk_t             req0_state = '0;
  blk_t             req1_state = '0;
  logic [1:0]       req_inv = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  blk_t             out_state;
  logic             out_id;
  logic             out_inv;
  logic             busy;
  logic [CNT_W-1:0] done_cnt0;
  logic [CNT_W-1:0] done_cnt1;

  int checks = 0;
  int failures = 0;

  // Reference model state: last grant and per-requester completion counts.
  bit m_last = ~RR_INIT;
  int m_done [2];

  mix_imix_col_scheduler #(.CNT_W(CNT_W), .RR_INIT(RR_INIT)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_state (req0_state),
    .req1_state (req1_state),
    .req_inv    (req_inv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_id     (out_id),
    .out_inv    (out_inv),
    .busy       (busy),
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Full-state matrix product with the circulant (inv)MixColumns matrix.
  function automatic blk_t mix_ref(input blk_t s, input bit inv);
    logic [7:0] coef [4];
    logic [7:0] r;
    blk_t res = '0;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++)
          r ^= gf_mul(coef[(j - i + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        res[127 - 32*c - 8*i -: 8] = r;
      end
    end
    return res;
  endfunction

  function automatic blk_t rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    req_valid = 2'b00;
    out_ready = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    m_last = ~RR_INIT;
    m_done = '{0, 0};
  endtask

  // Presents one request alone and returns at the negedge after the accept edge.
  task automatic drive_req(input int id, input blk_t st, input bit inv, output bit to);
    int n = 0;
    to = 1'b0;
    @(negedge ACLK);
    if (id == 0) req0_state = st;
    else         req1_state = st;
    req_inv[id]   = inv;
    req_valid[id] = 1'b1;
    #1;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    if (req_ready[id] !== 1'b1) to = 1'b1;
    else m_last = id[0];
    @(negedge ACLK);
    req_valid[id] = 1'b0;
    req_inv[id]   = ~inv;
    req0_state    = rand_blk();
    req1_state    = rand_blk();
  endtask

  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    to = (out_valid !== 1'b1);
  endtask

  task automatic pulse_ready(input bit id);
    out_ready = 1'b1;
    @(negedge ACLK);
    out_ready = 1'b0;
    m_done[id]++;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got valid=%b busy=%b ready=%b exp 0 0 00", out_valid, busy, req_ready);
    end
    checks++;
    if (out_state !== '0 || out_id !== 1'b0 || out_inv !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out got state=%h id=%b inv=%b exp 0", out_state, out_id, out_inv);
    end
    checks++;
    if (done_cnt0 !== '0 || done_cnt1 !== '0) begin
      failures++;
      $display("[TB] FAIL reset_cnt got %0d %0d exp 0 0", done_cnt0, done_cnt1);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reset_first_tie got ready=%b exp 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_vectors();
    blk_t vin [4];
    blk_t vexp [4];
    bit   vid [4];
    bit   vinv [4];
    bit   to1, to2;
    int   lat;
    vin  = '{{4{32'hdb135345}}, {4{32'h8e4da1bc}},
             {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5},
             {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}};
    vexp = '{{4{32'h8e4da1bc}}, {4{32'hdb135345}},
             {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6},
             {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}};
    vid  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vinv = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive_req(vid[k], vin[k], vinv[k], to1);
      wait_valid(lat, to2);
      checks++;
      if (to1 || to2 || lat != 4) begin
        failures++;
        $display("[TB] FAIL vec%0d_latency got lat=%0d acc_to=%b val_to=%b exp lat=4", k, lat, to1, to2);
      end
      checks++;
      if (out_state !== vexp[k]) begin
        failures++;
        $display("[TB] FAIL vec%0d_state got %h exp %h", k, out_state, vexp[k]);
      end
      checks++;
      if (out_id !== vid[k] || out_inv !== vinv[k]) begin
        failures++;
        $display("[TB] FAIL vec%0d_tag got id=%b inv=%b exp id=%b inv=%b", k, out_id, out_inv, vid[k], vinv[k]);
      end
      pulse_ready(vid[k]);
      checks++;
      if (done_cnt0 !== 16'(m_done[0]) || done_cnt1 !== 16'(m_done[1]) || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL vec%0d_done got cnt0=%0d cnt1=%0d busy=%b exp %0d %0d 0",
                 k, done_cnt0, done_cnt1, busy, m_done[0], m_done[1]);
      end
    end
  endtask

  task automatic test_stall();
    blk_t st = rand_blk();
    bit   inv = 1'($urandom);
    blk_t exp_st = mix_ref(st, inv);
    bit   to1, to2;
    int   lat;
    drive_req(1, st, inv, to1);
    wait_valid(lat, to2);
    checks++;
    if (to1 || to2) begin
      failures++;
      $display("[TB] FAIL stall_setup got acc_to=%b val_to=%b exp 0 0", to1, to2);
    end
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_state !== exp_st || out_id !== 1'b1 || out_inv !== inv ||
          req_ready !== 2'b00 || done_cnt0 !== 16'(m_done[0]) || done_cnt1 !== 16'(m_done[1])) begin
        failures++;
        $display("[TB] FAIL stall_hold cyc=%0d got v=%b st=%h id=%b inv=%b rdy=%b c0=%0d c1=%0d exp v=1 st=%h id=1 inv=%b rdy=00 c0=%0d c1=%0d",
                 i, out_valid, out_state, out_id, out_inv, req_ready, done_cnt0, done_cnt1,
                 exp_st, inv, m_done[0], m_done[1]);
      end
      @(negedge ACLK);
      req0_state = rand_blk();
      req1_state = rand_blk();
      req_inv    = 2'($urandom);
    end
    req_valid = 2'b00;
    pulse_ready(1'b1);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt1 !== 16'(m_done[1]) || done_cnt0 !== 16'(m_done[0])) begin
      failures++;
      $display("[TB] FAIL stall_release got busy=%b v=%b c0=%0d c1=%0d exp 0 0 %0d %0d",
               busy, out_valid, done_cnt0, done_cnt1, m_done[0], m_done[1]);
    end
  endtask

  task automatic test_reset_midop();
    blk_t st = rand_blk();
    bit   inv = 1'($urandom);
    bit   to1, to2;
    int   lat;
    drive_req(0, rand_blk(), 1'b0, to1);
    @(posedge ACLK);
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_state !== '0 || out_id !== 1'b0 ||
        out_inv !== 1'b0 || done_cnt0 !== '0 || done_cnt1 !== '0) begin
      failures++;
      $display("[TB] FAIL midop_reset got v=%b busy=%b st=%h id=%b inv=%b c0=%0d c1=%0d exp all 0",
               out_valid, busy, out_state, out_id, out_inv, done_cnt0, done_cnt1);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    m_last = ~RR_INIT;
    m_done = '{0, 0};
    drive_req(0, st, inv, to1);
    wait_valid(lat, to2);
    checks++;
    if (to1 || to2 || lat != 4 || out_state !== mix_ref(st, inv) || out_id !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midop_fresh got lat=%0d st=%h id=%b exp lat=4 st=%h id=0",
               lat, out_state, out_id, mix_ref(st, inv));
    end
    pulse_ready(1'b0);
    checks++;
    if (done_cnt0 !== 16'd1 || done_cnt1 !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midop_count got c0=%0d c1=%0d exp 1 0", done_cnt0, done_cnt1);
    end
  endtask

  // Cycle-level traffic against the model; directed mode keeps both requesters
  // and out_ready permanently high, random mode randomizes all handshakes.
  task automatic test_traffic(input int n_ops, input bit random_mode);
    blk_t exp_q [$];
    bit   id_q [$];
    bit   inv_q [$];
    int   acc_cycle [$];
    bit   acc_id [$];
    bit   m_idle = 1'b1;
    int   m_cnt = 0;
    int   done_ops = 0;
    int   cyc = 0;
    bit   exp_valid, w;
    logic [1:0] exp_ready;
    while (done_ops < n_ops && cyc < 2000) begin
      @(negedge ACLK);
      cyc++;
      if (!m_idle) m_cnt++;
      exp_valid = !m_idle && m_cnt >= 4;
      checks++;
      if (out_valid !== exp_valid) begin
        failures++;
        $display("[TB] FAIL traffic_valid cyc=%0d got %b exp %b", cyc, out_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (out_state !== exp_q[0] || out_id !== id_q[0] || out_inv !== inv_q[0]) begin
          failures++;
          $display("[TB] FAIL traffic_result cyc=%0d got st=%h id=%b inv=%b exp st=%h id=%b inv=%b",
                   cyc, out_state, out_id, out_inv, exp_q[0], id_q[0], inv_q[0]);
        end
      end
      checks++;
      if (done_cnt0 !== 16'(m_done[0]) || done_cnt1 !== 16'(m_done[1])) begin
        failures++;
        $display("[TB] FAIL traffic_count cyc=%0d got %0d %0d exp %0d %0d",
                 cyc, done_cnt0, done_cnt1, m_done[0], m_done[1]);
      end
      req0_state = rand_blk();
      req1_state = rand_blk();
      req_inv    = 2'($urandom);
      req_valid  = random_mode ? 2'($urandom_range(0, 3)) : 2'b11;
      out_ready  = random_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      w = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      exp_ready = (m_idle && req_valid != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (req_ready !== exp_ready || busy !== !m_idle) begin
        failures++;
        $display("[TB] FAIL traffic_ready cyc=%0d got rdy=%b busy=%b exp rdy=%b busy=%b",
                 cyc, req_ready, busy, exp_ready, !m_idle);
      end
      if (m_idle && req_valid != 2'b00) begin
        exp_q.push_back(mix_ref(w ? req1_state : req0_state, req_inv[w]));
        id_q.push_back(w);
        inv_q.push_back(req_inv[w]);
        acc_cycle.push_back(cyc);
        acc_id.push_back(w);
        m_last = w;
        m_idle = 1'b0;
        m_cnt  = -1;
      end else if (exp_valid && out_ready) begin
        m_done[id_q[0]]++;
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        void'(inv_q.pop_front());
        m_idle = 1'b1;
        done_ops++;
      end
    end
    @(negedge ACLK);
    req_valid = 2'b00;
    out_ready = 1'b0;
    #1;
    checks++;
    if (done_ops != n_ops || done_cnt0 !== 16'(m_done[0]) || done_cnt1 !== 16'(m_done[1])) begin
      failures++;
      $display("[TB] FAIL traffic_end got ops=%0d c0=%0d c1=%0d exp ops=%0d c0=%0d c1=%0d",
               done_ops, done_cnt0, done_cnt1, n_ops, m_done[0], m_done[1]);
    end
    if (!random_mode) begin
      for (int k = 0; k < acc_id.size(); k++) begin
        checks++;
        if (acc_id[k] !== 1'(k % 2)) begin
          failures++;
          $display("[TB] FAIL b2b_order op=%0d got id=%b exp id=%0d", k, acc_id[k], k % 2);
        end
        if (k > 0) begin
          checks++;
          if (acc_cycle[k] - acc_cycle[k-1] != 6) begin
            failures++;
            $display("[TB] FAIL b2b_spacing op=%0d got %0d exp 6", k, acc_cycle[k] - acc_cycle[k-1]);
          end
        end
      end
      checks++;
      if (done_cnt0 !== 16'd2 || done_cnt1 !== 16'd2) begin
        failures++;
        $display("[TB] FAIL b2b_counts got %0d %0d exp 2 2", done_cnt0, done_cnt1);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    test_traffic(4, 1'b0);
  endtask

  task automatic test_random();
    test_traffic(40, 1'b1);
  endtask

  initial begin
    m_done = '{0, 0};
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    test_reset();
    test_vectors();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
